pn_seq_checker: RTL and testbench

- Receive-side PN checker for the 8-bit m-sequence generated on the transmit side.
- Consumes a serial bit stream (loopback or demodulated) and self-synchronises a local 8-bit Fibonacci LFSR to it.
- Verifies alignment, then reports lock status and bit errors for link BER testing.
- Sits directly downstream of the m-sequence generator / demodulator bit output.

---
 rtl/pn_seq_checker_if.sv | 21 ++
 rtl/pn_seq_checker.sv | 142 ++++++++++++++
 tb/tb_pn_seq_checker.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pn_seq_checker_if.sv
// Bit-stream and status bundle for the PN sequence checker.
// The master drives the received bits; the slave (checker) returns lock and error statistics.
interface pn_seq_checker_if;
  logic        in_valid;
  logic        in_bit;
  logic        clr_stats;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  modport master (
    output in_valid, in_bit, clr_stats,
    input  locked, err_pulse, err_cnt, bit_cnt
  );

  modport slave (
    input  in_valid, in_bit, clr_stats,
    output locked, err_pulse, err_cnt, bit_cnt
  );
endinterface

// File: rtl/pn_seq_checker.sv
// Receive-side PN checker: self-synchronises an 8-bit Fibonacci LFSR to the incoming stream.
// Define PN_CHK_STATS_EN to build the err_cnt/bit_cnt statistics counters; otherwise they read 0.
//
// state  | meaning
// SEARCH | filling the local register with 8 received bits
// VERIFY | comparing predictions against received bits until VERIFY_LEN agree
// LOCK   | free-running prediction, counting errors per ERR_WIN window
module pn_seq_checker #(
  parameter logic [7:0] POLY       = 8'b10001110,
  parameter int         VERIFY_LEN = 16,
  parameter int         ERR_WIN    = 64,
  parameter int         ERR_THRESH = 8
) (
  input logic            sclk,
  input logic            rst_n,
  pn_seq_checker_if.slave bus
);

  localparam int MW = $clog2(VERIFY_LEN + 1);
  localparam int WW = $clog2(ERR_WIN);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [MW-1:0] VERIFY_LAST = MW'(VERIFY_LEN - 1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(ERR_WIN - 1);
  localparam logic [EW-1:0] THRESH_V    = EW'(ERR_THRESH);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [2:0]    fill_cnt;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  logic          locked_r;
  logic          err_pulse_r;

  logic          pred;
  logic          mismatch;
  logic [7:0]    lfsr_next;
  logic [EW-1:0] win_err_next;
  logic          lock_bit;

  always_comb begin
    pred = 1'b0;
    for (int i = 0; i < 8; i++) pred = pred ^ (lfsr[i] & POLY[7-i]);
    mismatch     = bus.in_bit ^ pred;
    // In LOCK the register free-runs so received errors cannot corrupt it.
    lfsr_next    = {(state == LOCK) ? pred : bus.in_bit, lfsr[7:1]};
    win_err_next = win_err + EW'(mismatch);
    lock_bit     = bus.in_valid && (state == LOCK);
  end

  always_ff @(posedge sclk or posedge rst_n) begin
    if (rst_n) begin
      state       <= SEARCH;
      lfsr        <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= 1'b0;
      if (bus.in_valid) begin
        lfsr <= lfsr_next;
        case (state)
          SEARCH: begin
            if (fill_cnt == 3'd7) begin
              fill_cnt <= '0;
              if (lfsr_next != 8'h00) begin
                state     <= VERIFY;
                match_cnt <= '0;
              end
            end else begin
              fill_cnt <= fill_cnt + 3'd1;
            end
          end
          VERIFY: begin
            if (mismatch) begin
              state    <= SEARCH;
              fill_cnt <= '0;
            end else if (match_cnt == VERIFY_LAST) begin
              state    <= LOCK;
              locked_r <= 1'b1;
              win_cnt  <= '0;
              win_err  <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          LOCK: begin
            err_pulse_r <= mismatch;
            // Threshold is tested before the window wrap so a last-bit error still counts.
            if (win_err_next == THRESH_V) begin
              state    <= SEARCH;
              fill_cnt <= '0;
              locked_r <= 1'b0;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              win_err <= win_err_next;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign bus.locked    = locked_r;
  assign bus.err_pulse = err_pulse_r;

`ifdef PN_CHK_STATS_EN
  logic [15:0] err_cnt_r;
  logic [31:0] bit_cnt_r;

  always_ff @(posedge sclk or posedge rst_n) begin
    if (rst_n) begin
      err_cnt_r <= '0;
      bit_cnt_r <= '0;
    end else if (bus.clr_stats) begin
      err_cnt_r <= '0;
      bit_cnt_r <= '0;
    end else if (lock_bit) begin
      if (bit_cnt_r != 32'hFFFF_FFFF) bit_cnt_r <= bit_cnt_r + 32'd1;
      if (mismatch && (err_cnt_r != 16'hFFFF)) err_cnt_r <= err_cnt_r + 16'd1;
    end
  end

  assign bus.err_cnt = err_cnt_r;
  assign bus.bit_cnt = bit_cnt_r;
`else
  logic unused_stats;
  assign unused_stats = bus.clr_stats ^ lock_bit;
  assign bus.err_cnt  = '0;
  assign bus.bit_cnt  = '0;
`endif

endmodule

// File: tb/tb_pn_seq_checker.sv
// Randomised self-checking bench for pn_seq_checker against a bit-history reference model.
module tb_pn_seq_checker;

`ifdef PN_CHK_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif
  localparam int VERIFY_LEN = 16;
  localparam int ERR_WIN    = 64;
  localparam int ERR_THRESH = 8;

  typedef bit hist_t[$];

  logic sclk;
  logic rst_n;
  pn_seq_checker_if bus ();

  pn_seq_checker dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] poly_v = 8'b10001110;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Next bit of the sequence given the last 8 bits, oldest first.
  function automatic bit pn_pred(input hist_t h);
    bit x = 1'b0;
    for (int i = 0; i < 8; i++) x = x ^ (h[i] & poly_v[7-i]);
    return x;
  endfunction

  // Transmit-side generator
  hist_t tx_q;
  task automatic tx_seed();
    tx_q.delete();
    for (int i = 0; i < 8; i++) tx_q.push_back(1'b1);
  endtask
  function automatic bit gen_next();
    bit b = pn_pred(tx_q);
    tx_q.push_back(b);
    void'(tx_q.pop_front());
    return b;
  endfunction

  // Reference model: mode 0 search, 1 verify, 2 lock
  hist_t  m_q;
  int     m_mode, m_cnt, m_win_pos, m_win_err;
  longint m_err, m_bits;
  bit     m_pulse;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 8; i++) m_q.push_back(1'b0);
    m_mode = 0; m_cnt = 0; m_win_pos = 0; m_win_err = 0;
    m_err = 0; m_bits = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit c);
    bit p;
    bit all_zero;
    m_pulse = 1'b0;
    if (v) begin
      p = pn_pred(m_q);
      m_q.push_back((m_mode == 2) ? p : b);
      void'(m_q.pop_front());
      if (m_mode == 0) begin
        m_cnt++;
        if (m_cnt == 8) begin
          all_zero = 1'b1;
          foreach (m_q[i]) if (m_q[i]) all_zero = 1'b0;
          m_cnt = 0;
          if (!all_zero) m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (b == p) begin
          m_cnt++;
          if (m_cnt == VERIFY_LEN) begin
            m_mode = 2; m_win_pos = 0; m_win_err = 0;
          end
        end else begin
          m_mode = 0; m_cnt = 0;
        end
      end else begin
        if (m_bits < 64'hFFFF_FFFF) m_bits++;
        if (b != p) begin
          m_pulse = 1'b1;
          m_win_err++;
          if (m_err < 65535) m_err++;
        end
        if (m_win_err >= ERR_THRESH) begin
          m_mode = 0; m_cnt = 0;
        end else if (m_win_pos == ERR_WIN - 1) begin
          m_win_pos = 0; m_win_err = 0;
        end else begin
          m_win_pos++;
        end
      end
    end
    if (c) begin
      m_err = 0; m_bits = 0;
    end
  endtask

  task automatic cycle(input bit v, input bit b, input bit c);
    bus.in_valid  = v;
    bus.in_bit    = b;
    bus.clr_stats = c;
    @(posedge sclk);
    #1;
    model_step(v, b, c);
    chk("locked",    bus.locked,    m_mode == 2);
    chk("err_pulse", bus.err_pulse, m_pulse);
    chk("err_cnt",   bus.err_cnt,   STATS_EN ? m_err : 0);
    chk("bit_cnt",   bus.bit_cnt,   STATS_EN ? m_bits : 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clr_stats = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_locked",    bus.locked,    0);
    chk("rst_err_pulse", bus.err_pulse, 0);
    chk("rst_err_cnt",   bus.err_cnt,   0);
    chk("rst_bit_cnt",   bus.bit_cnt,   0);
    rst_n = 1'b0;
    model_reset();
    tx_seed();
  endtask

  task automatic acquire(input string tag);
    for (int k = 1; k <= 24; k++) begin
      cycle(1'b1, gen_next(), 1'b0);
      if (k == 23) chk({tag, "_b23"}, bus.locked, 0);
      if (k == 24) chk({tag, "_b24"}, bus.locked, 1);
    end
  endtask

  initial begin
    bit b;
    int errs;
    int k;
    int guard;
    bit v;

    do_reset();

    // Lock acquisition and clean run
    acquire("acq");
    for (int i = 0; i < 100; i++) cycle(1'b1, gen_next(), 1'b0);
    chk("bit_cnt_100", bus.bit_cnt, STATS_EN ? 100 : 0);

    // Single inverted bit
    b = gen_next();
    cycle(1'b1, ~b, 1'b0);
    chk("single_pulse",  bus.err_pulse, 1);
    chk("single_errcnt", bus.err_cnt,   STATS_EN ? 1 : 0);
    chk("single_locked", bus.locked,    1);
    for (int i = 0; i < 40; i++) cycle(1'b1, gen_next(), 1'b0);
    chk("single_after", bus.err_cnt, STATS_EN ? 1 : 0);

    // Eight errors inside one window
    cycle(1'b0, 1'b0, 1'b1);
    guard = 0;
    while (m_win_pos != 0 && guard < ERR_WIN) begin
      cycle(1'b1, gen_next(), 1'b0);
      guard++;
    end
    errs = 0;
    for (int i = 0; i < 60 && errs < 8; i++) begin
      b = gen_next();
      if (m_win_pos % 5 == 0 && m_win_pos >= 10) begin
        b = ~b;
        errs++;
      end
      cycle(1'b1, b, 1'b0);
    end
    chk("loss_locked", bus.locked,  0);
    chk("loss_errcnt", bus.err_cnt, STATS_EN ? 8 : 0);
    acquire("relock");

    // Seven errors per window over three windows
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3 * ERR_WIN; i++) begin
      b = gen_next();
      if (m_win_pos % 5 == 0 && m_win_pos >= 5 && m_win_pos <= 35) b = ~b;
      cycle(1'b1, b, 1'b0);
    end
    chk("seven_locked", bus.locked,  1);
    chk("seven_errcnt", bus.err_cnt, STATS_EN ? 21 : 0);

    // Clear coinciding with an error
    b = gen_next();
    cycle(1'b1, ~b, 1'b1);
    chk("clr_err_errcnt", bus.err_cnt,   0);
    chk("clr_err_pulse",  bus.err_pulse, 1);

    // Asynchronous reset while locked
    rst_n = 1'b1;
    #2;
    chk("arst_locked",    bus.locked,    0);
    chk("arst_err_pulse", bus.err_pulse, 0);
    chk("arst_err_cnt",   bus.err_cnt,   0);
    chk("arst_bit_cnt",   bus.bit_cnt,   0);
    model_reset();
    do_reset();

    // All-zero stream
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("zero_locked", bus.locked, 0);

    // Mismatch at verify bit 10
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1'b1, gen_next(), 1'b0);
    b = gen_next();
    cycle(1'b1, ~b, 1'b0);
    acquire("vfail");

    // Random valid gaps
    do_reset();
    k = 0;
    guard = 0;
    while (k < 24 && guard < 1000) begin
      v = ($urandom % 2) == 1;
      b = v ? gen_next() : 1'($urandom % 2);
      cycle(v, b, 1'b0);
      if (v) begin
        k++;
        if (k == 23) chk("gap_b23", bus.locked, 0);
        if (k == 24) chk("gap_b24", bus.locked, 1);
      end
      guard++;
    end
    chk("gap_reached", k, 24);

    // Random errors, gaps and clears
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom % 4) != 0;
      b = v ? gen_next() : 1'($urandom % 2);
      if (v && ($urandom % 24) == 0) b = ~b;
      cycle(v, b, ($urandom % 200) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
